// File: rtl/seq_multiplier_16.sv
// Unsigned WIDTH x WIDTH radix-2 shift-and-add multiplier with a valid/ready handshake on each side.
// Latency: WIDTH+1 edges from acceptance to out_valid; one operation in flight at a time.
// Backpressure: the result holds in DONE while out_ready=0; in_ready stays low until it is taken.
module seq_multiplier_16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  // Counter must be able to hold WIDTH itself so it never wraps inside an operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     mcand;   // captured multiplicand
  logic [2*WIDTH-1:0]   work;    // {upper accumulator, lower multiplier/result bits}
  logic [CW-1:0]        step;
  logic [WIDTH:0]       sum;     // upper half plus optional multiplicand, carry kept
  logic                 accept;
  logic                 out_fire;
  logic                 last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = work;

  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_step = (step == LAST_STEP);

  // One shift-and-add step: add the multiplicand when the current multiplier LSB is set.
  always_comb begin
    sum = {1'b0, work[2*WIDTH-1:WIDTH]};
    if (work[0]) begin
      sum = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
  end

  // Next-state decode; always runs the full WIDTH steps regardless of operand values.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: if (out_fire)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // State register; reset wins over everything, discarding any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: load operands on accept, shift {carry, upper, lower} right once per CALC cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      work  <= '0;
      step  <= '0;
    end else if (accept) begin
      mcand <= a;
      work  <= {{WIDTH{1'b0}}, b};
      step  <= '0;
    end else if (state == CALC) begin
      work  <= {sum, work[WIDTH-1:1]};
      step  <= step + CW'(1);
    end
  end

endmodule
